// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI bus arbiter.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, OWNED, BUSY} arb_state_t;

  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

  // True when at most one bit of v is set; callers zero-extend to 8 bits.
  function automatic logic onehot_valid(input logic [7:0] v);
    return (v & (v - 8'd1)) == 8'd0;
  endfunction

endpackage

// File: rtl/spi_arb_pick.sv
// Combinational winner select: first requester at or after ptr (wrapping).
module spi_arb_pick #(
  parameter int N  = 2,
  parameter int OW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] ptr,
  output logic [OW-1:0] idx,
  output logic          valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      int          j;
      logic [OW-1:0] jj;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      jj = OW'(j);
      if (!valid && req[jj]) begin
        valid = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one spi_controller among NUM_MASTERS requesters via a registered req/gnt handshake.
// Define SPI_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index priority.
module spi_bus_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int MEM_SIZE    = 30,
  localparam int AW         = $clog2(MEM_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_MASTERS-1:0]    req,
  output logic [NUM_MASTERS-1:0]    gnt,
  input  logic [NUM_MASTERS-1:0]    m_op,
  input  logic [NUM_MASTERS-1:0]    m_start,
  input  logic [NUM_MASTERS-1:0]    m_ss,
  input  logic [NUM_MASTERS*AW-1:0] m_size,
  input  logic [NUM_MASTERS*8-1:0]  m_data_in,
  output logic [NUM_MASTERS-1:0]    m_done,
  output logic [NUM_MASTERS-1:0]    m_wr,
  output logic                      spi_op,
  output logic                      spi_start,
  output logic [AW-1:0]             spi_size,
  output logic [7:0]                spi_data_in,
  output logic                      spi_ss,
  input  logic                      spi_done,
  input  logic                      spi_wr,
  output logic                      busy,
  output arb_state_t                state_dbg
);

  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  // Handshake: a master holds req high as long as it wants the bus; gnt is
  // registered and rises one cycle after req. The owner keeps the bus until it
  // drops req outside a transfer, or until spi_done with req low.
  arb_state_t      state;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   pick_ptr;
  logic [OW-1:0]   pick_idx;
  logic            pick_valid;

`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic [OW-1:0]   ptr;
  assign pick_ptr = ptr;
`else
  assign pick_ptr = '0;
`endif

  spi_arb_pick #(.N(NUM_MASTERS), .OW(OW)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      ptr   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick_idx;
            gnt   <= NUM_MASTERS'(1) << pick_idx;
            state <= OWNED;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            ptr   <= (int'(pick_idx) == NUM_MASTERS - 1) ? '0 : OW'(pick_idx + 1'b1);
`endif
          end
        end
        OWNED: begin
          // A start in the same cycle as a req drop still launches the transfer.
          if (m_start[owner]) begin
            state <= BUSY;
            busy  <= 1'b1;
          end else if (!req[owner]) begin
            state <= IDLE;
            gnt   <= '0;
          end
        end
        BUSY: begin
          if (spi_done) begin
            busy <= 1'b0;
            if (req[owner]) begin
              state <= OWNED;
            end else begin
              state <= IDLE;
              gnt   <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    spi_op      = 1'b0;
    spi_start   = 1'b0;
    spi_size    = '0;
    spi_data_in = SPI_IDLE_BYTE;
    spi_ss      = 1'b1;
    m_done      = '0;
    m_wr        = '0;
    if (state != IDLE) begin
      spi_op      = m_op[owner];
      spi_start   = m_start[owner];
      spi_ss      = m_ss[owner];
      spi_size    = m_size[owner*AW +: AW];
      spi_data_in = m_data_in[owner*8 +: 8];
    end
    if (state == BUSY) begin
      m_done[owner] = spi_done;
      m_wr[owner]   = spi_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!busy || gnt != '0);
      assert (onehot_valid(8'(gnt)));
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with two masters and a 30-byte buffer.
module tb_spi_bus_arbiter;
  import spi_pkg::*;

  localparam int N  = 2;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, gnt, m_op, m_start, m_ss, m_done, m_wr;
  logic [N*AW-1:0] m_size;
  logic [N*8-1:0]  m_data_in;
  logic            spi_op, spi_start, spi_ss, spi_done, spi_wr, busy;
  logic [AW-1:0]   spi_size;
  logic [7:0]      spi_data_in;
  arb_state_t      state_dbg;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  spi_bus_arbiter #(.NUM_MASTERS(N), .MEM_SIZE(30)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .m_op(m_op), .m_start(m_start), .m_ss(m_ss), .m_size(m_size),
    .m_data_in(m_data_in), .m_done(m_done), .m_wr(m_wr),
    .spi_op(spi_op), .spi_start(spi_start), .spi_size(spi_size),
    .spi_data_in(spi_data_in), .spi_ss(spi_ss), .spi_done(spi_done),
    .spi_wr(spi_wr), .busy(busy), .state_dbg(state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:0] rr_exp;

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    m_op      = 2'b10;
    m_start   = '0;
    m_ss      = 2'b11;
    m_size    = {5'd15, 5'd7};
    m_data_in = {8'h5A, 8'hC3};
    spi_done  = 1'b0;
    spi_wr    = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_ss", spi_ss, 1);
    check("rst_start", spi_start, 0);
    check("rst_op", spi_op, 0);
    check("rst_size", spi_size, 0);
    check("rst_data", spi_data_in, 8'hFF);
    check("rst_done", m_done, 0);
    rst_n = 1'b1;
    tick();

    // Single master 1: grant one cycle after req
    req = 2'b10;
    #1;
    check("m1_gnt_before_edge", gnt, 0);
    tick();
    check("m1_gnt", gnt, 2'b10);
    check("m1_busy_owned", busy, 0);
    check("m1_size", spi_size, 15);
    check("m1_op", spi_op, 1);
    check("m1_data", spi_data_in, 8'h5A);
    check("m1_ss_high", spi_ss, 1);
    m_ss[1] = 1'b0;
    m_start[1] = 1'b1;
    #1;
    check("m1_start_comb", spi_start, 1);
    check("m1_ss_low", spi_ss, 0);
    tick();
    m_start = '0;
    check("m1_busy", busy, 1);
    spi_done = 1'b1;
    spi_wr   = 1'b1;
    #1;
    check("m1_done_route", m_done, 2'b10);
    check("m1_wr_route", m_wr, 2'b10);
    tick();
    spi_done = 1'b0;
    spi_wr   = 1'b0;
    check("m1_b2b_gnt", gnt, 2'b10);
    check("m1_b2b_busy", busy, 0);
    check("m1_b2b_state", state_dbg, OWNED);
    req = 2'b00;
    m_ss = 2'b11;
    tick();
    check("m1_rel_gnt", gnt, 0);
    check("m1_rel_ss", spi_ss, 1);
    check("m1_rel_data", spi_data_in, 8'hFF);
    spi_done = 1'b1;
    #1;
    check("idle_done_ignored", m_done, 0);
    tick();
    spi_done = 1'b0;
    check("idle_done_state", state_dbg, IDLE);

    // Simultaneous requests: master 0 wins
    req = 2'b11;
    tick();
    check("both_gnt", gnt, 2'b01);
    check("own_op0", spi_op, 0);
    check("own_data0", spi_data_in, 8'hC3);
    // Non-owner isolation while OWNED
    m_ss      = 2'b01;
    m_start   = 2'b10;
    #1;
    check("iso_start", spi_start, 0);
    check("iso_ss", spi_ss, 1);
    tick();
    check("iso_no_busy", busy, 0);
    m_start = 2'b01;
    m_ss    = 2'b00;
    tick();
    m_start = '0;
    check("m0_busy", busy, 1);
    spi_wr = 1'b1;
    #1;
    check("m0_wr_route", m_wr, 2'b01);
    spi_wr = 1'b0;

    // Release mid-transfer: bus held until spi_done
    req = 2'b10;
    tick();
    tick();
    check("hold_gnt", gnt, 2'b01);
    check("hold_busy", busy, 1);
    check("hold_ss", spi_ss, 0);
    m_ss[0] = 1'b1;
    #1;
    check("hold_ss_follow", spi_ss, 1);
    m_ss[0] = 1'b0;
    spi_done = 1'b1;
    #1;
    check("m0_done_route", m_done, 2'b01);
    tick();
    spi_done = 1'b0;
    check("m0_rel_gnt", gnt, 0);
    check("m0_rel_ss", spi_ss, 1);
    tick();
    check("m1_after_m0", gnt, 2'b10);

    // Reset in the middle of a transfer
    m_start = 2'b10;
    tick();
    m_start = '0;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    check("midrst_gnt", gnt, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ss", spi_ss, 1);
    check("midrst_data", spi_data_in, 8'hFF);
    req   = '0;
    m_ss  = 2'b11;
    rst_n = 1'b1;
    tick();

    // Repeated release/re-request with both masters requesting
    req = 2'b11;
    tick();
    check("rr_first", gnt, 2'b01);
    rr_exp = 2'b01;
    for (int k = 0; k < 3; k++) begin
      req = ~gnt;
      tick();
      check("rr_release", gnt, 0);
      req = 2'b11;
      tick();
`ifdef SPI_ARB_ROUND_ROBIN_EN
      rr_exp = ~rr_exp;
`endif
      check("rr_grant", gnt, {30'd0, rr_exp});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one spi_controller instance between NUM_MASTERS requesters, e.g. the power-up sequencer (master 0) and sd_controller (master 1).
- Replaces the ad-hoc one-bit owner mux in the top level.
- Uses a registered req/gnt handshake and muxes the command bundle to the SPI controller.
- Routes done/wr strobes back only to the current owner.
- Never revokes ownership while a transfer is in flight.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- MEM_SIZE, 30, SPI buffer depth in bytes; sets size/address width.
- AW, $clog2(MEM_SIZE), width of the size/address fields (derived; do not override).

Ports:
- clk  in  1  system clock (SPI-domain divided clock).
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- req  in  NUM_MASTERS  level request, one bit per master.
- gnt  out  NUM_MASTERS  one-hot grant, registered.
- m_op  in  NUM_MASTERS  per-master op bit.
- m_start  in  NUM_MASTERS  per-master start pulse.
- m_ss  in  NUM_MASTERS  per-master slave select (active low).
- m_size  in  NUM_MASTERS*AW  per-master size, packed with master i at [i*AW +: AW].
- m_data_in  in  NUM_MASTERS*8  per-master fill byte, packed with master i at [i*8 +: 8].
- m_done  out  NUM_MASTERS  spi_done routed to the owner only.
- m_wr  out  NUM_MASTERS  spi_wr routed to the owner only.
- spi_op  out  1  to spi_controller.
- spi_start  out  1  to spi_controller.
- spi_size  out  AW  to spi_controller.
- spi_data_in  out  8  to spi_controller.
- spi_ss  out  1  to SD card CS pin.
- spi_done  in  1  from spi_controller.
- spi_wr  in  1  from spi_controller.
- busy  out  1  high while a transfer is in flight (state BUSY).

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, gnt=0, owner=0, busy=0, priority pointer=0.
  - Outputs after reset: spi_ss=1, spi_start=0, spi_op=0, spi_size=0, spi_data_in=8'hFF.
  - Reset mid-transfer abandons the transfer immediately. The SPI controller is reset by the same rst_n.
- States: IDLE, OWNED, BUSY.
- IDLE:
  - The bus drives idle values (ss=1, start=0, data_in=FF).
  - If any req bit is high, select a winner (fixed priority, lowest index wins), register owner, set gnt[owner] next cycle, go to OWNED.
  - Latency: req rises at cycle t, gnt is high at t+1.
- OWNED:
  - spi_* = owner's bundle, combinational from the registered owner.
  - Non-owner m_start/m_ss are ignored.
  - On m_start[owner]=1, go to BUSY and set busy=1 the next cycle.
  - If req[owner]=0 (and no start that cycle), drop gnt and go to IDLE the next cycle.
  - If start and req-drop coincide, start wins and the state goes to BUSY.
- BUSY:
  - The mux stays on the owner.
  - spi_done goes to m_done[owner]; spi_wr goes to m_wr[owner]. Other m_done/m_wr bits are 0.
  - When spi_done=1: if req[owner] is still high, go to OWNED (back-to-back transfers without re-arbitration); otherwise go to IDLE, gnt=0.
  - req falling during BUSY does not release the bus before spi_done.
- No arbitration while OWNED or BUSY. Competing requests wait.
- spi_start is not registered, so the owner's start pulse reaches the controller in the same cycle.
- gnt is always one-hot or zero. Assertion: busy implies gnt!=0.
- A spi_done arriving in IDLE is ignored, and m_done stays 0.

Optional Feature:
- SPI_ARB_ROUND_ROBIN_EN:
  - Defined: on grant, the pointer becomes owner+1 (mod NUM_MASTERS), and the search starts from the pointer. A master that just released ranks lowest.
  - Undefined: fixed priority, lowest index wins, and no pointer register exists.

Decomposition:
- Package spi_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, OWNED, BUSY};
  - constant SPI_IDLE_BYTE = 8'hFF;
  - function onehot_valid.
- One sub-module, spi_arb_pick: combinational winner select (req, pointer) -> index + valid. It is shared by both priority modes.

Test Plan:
- Single master: req[1]=1 at cycle 5 -> gnt=2'b10 at cycle 6. m_start[1] pulse with m_size=15, m_ss=0 -> spi_start=1 the same cycle, spi_size=15, spi_ss=0, busy=1 the next cycle. spi_done pulse -> m_done=2'b10, m_done[0]=0.
- Simultaneous req=2'b11 from reset -> gnt=2'b01 (fixed priority). Master 0 drops req after done -> gnt=2'b10 within 2 cycles.
- Release mid-transfer: master 0 drops req in BUSY -> gnt holds 2'b01 and spi_ss follows m_ss[0] until spi_done, then gnt=0 and spi_ss=1.
- Non-owner isolation: owner=0, m_start[1]=1, m_ss[1]=0 -> spi_start=0, spi_ss=m_ss[0]. spi_wr pulses appear only on m_wr[0].
- Reset mid-BUSY: rst_n=0 for one posedge -> gnt=0, busy=0, spi_ss=1, spi_data_in=8'hFF the following cycle.
- With SPI_ARB_ROUND_ROBIN_EN and both req held, 4 back-to-back release/re-request cycles -> grants alternate 01,10,01,10.
